// File: rtl/cfg_loader.sv
// Serial config bitstream loader: assembles BITS_W-bit words, writes one per routing block.
// Optional even-parity check per word when CFG_PARITY_EN is defined.
module cfg_loader #(
    parameter int BITS_W  = 18,
    parameter int NUM_BLK = 4,
    parameter int IDX_W   = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cfg_din,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [BITS_W-1:0] bits,
    output logic [NUM_BLK-1:0] wr_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(BITS_W + 1);
`ifdef CFG_PARITY_EN
    localparam int LAST_BIT = BITS_W;
`else
    localparam int LAST_BIT = BITS_W - 1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WRITE,
        ST_DONE
`ifdef CFG_PARITY_EN
        , ST_ERR
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [BITS_W-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     blk_idx_q, blk_idx_d;
    logic [BITS_W-1:0]    bits_q, bits_d;
    logic [NUM_BLK-1:0]   wr_en_q, wr_en_d;
    logic [NUM_BLK-1:0]   blk_oh;
    logic                 xfer;

    assign cfg_ready = (state_q == ST_SHIFT);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
`ifdef CFG_PARITY_EN
    assign err       = (state_q == ST_ERR);
`else
    assign err       = 1'b0;
`endif
    assign bits      = bits_q;
    assign wr_en     = wr_en_q;
    assign xfer      = cfg_valid & cfg_ready;

    always_comb begin
        blk_oh = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            blk_oh[i] = (blk_idx_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        blk_idx_d = blk_idx_q;
        bits_d    = bits_q;
        wr_en_d   = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    blk_idx_d = '0;
                end
            end
`ifdef CFG_PARITY_EN
            ST_ERR: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    blk_idx_d = '0;
                end
            end
`endif
            ST_SHIFT: begin
                if (xfer) begin
                    shreg_d   = {shreg_q[BITS_W-2:0], cfg_din};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(LAST_BIT)) begin
                        bit_cnt_d = '0;
`ifdef CFG_PARITY_EN
                        // trailing bit is parity only; keep the data word
                        shreg_d = shreg_q;
                        if (^{shreg_q, cfg_din} == 1'b0) begin
                            bits_d  = shreg_q;
                            wr_en_d = blk_oh;
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_ERR;
                        end
`else
                        bits_d  = {shreg_q[BITS_W-2:0], cfg_din};
                        wr_en_d = blk_oh;
                        state_d = ST_WRITE;
`endif
                    end
                end
            end
            ST_WRITE: begin
                if (blk_idx_q == IDX_W'(NUM_BLK - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    blk_idx_d = blk_idx_q + IDX_W'(1);
                    state_d   = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            blk_idx_q <= '0;
            bits_q    <= '0;
            wr_en_q   <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            blk_idx_q <= blk_idx_d;
            bits_q    <= bits_d;
            wr_en_q   <= wr_en_d;
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Scoreboard bench for cfg_loader: expected writes queued at stimulus, checked on wr_en.
`timescale 1ns/1ps
module tb_cfg_loader;

    localparam int BW = 18;
    localparam int NB = 4;
`ifdef CFG_PARITY_EN
    localparam int PER = BW + 2;
`else
    localparam int PER = BW + 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          cfg_din = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [BW-1:0] bits;
    logic [NB-1:0] wr_en;
    logic          busy;
    logic          done;
    logic          err;

    cfg_loader #(.BITS_W(BW), .NUM_BLK(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_din(cfg_din),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .bits(bits),
        .wr_en(wr_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            blk;
        logic [BW-1:0] word;
    } exp_t;

    exp_t    exp_q[$];
    int      wr_cyc[$];
    int      n_chk = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      start_cyc = 0;
    int      exp_blk = 0;
    bit      mon_en = 1'b0;
    logic [BW-1:0] last_bits = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                last_bits = '0;
            end else if (wr_en != '0) begin
                exp_t e;
                logic [NB-1:0] oh;
                n_chk++;
                if (cfg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ready_in_write: got %b want 0", cfg_ready);
                end
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: wr_en=%b bits=%h", wr_en, bits);
                end else begin
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e.blk] = 1'b1;
                    n_chk++;
                    if (wr_en !== oh) begin
                        n_fail++;
                        $display("FAIL wr_en: got %b want %b", wr_en, oh);
                    end
                    n_chk++;
                    if (bits !== e.word) begin
                        n_fail++;
                        $display("FAIL bits: got %h want %h", bits, e.word);
                    end
                end
                wr_cyc.push_back(cyc);
                last_bits = bits;
            end else begin
                n_chk++;
                if (bits !== last_bits) begin
                    n_fail++;
                    $display("FAIL bits_hold: got %h want %h", bits, last_bits);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input int gap);
        bit sent = 1'b0;
        int guard = 0;
        while (!sent) begin
            @(negedge clk);
            if ($urandom_range(99) < gap) begin
                cfg_valid = 1'b0;
            end else begin
                cfg_valid = 1'b1;
                cfg_din = b;
                if (cfg_ready === 1'b1) begin
                    @(posedge clk);
                    sent = 1'b1;
                end
            end
            guard++;
            if (!sent && guard > 300) begin
                n_chk++; n_fail++;
                $display("FAIL send_timeout: ready=%b want 1", cfg_ready);
                sent = 1'b1;
            end
        end
    endtask

    task automatic send_range(input logic [BW-1:0] w, input int hi,
                              input int lo, input int gap);
        for (int i = hi; i >= lo; i--) send_bit(w[i], gap);
    endtask

    task automatic expect_word(input logic [BW-1:0] w);
        exp_t e;
        e.blk = exp_blk;
        e.word = w;
        exp_q.push_back(e);
        exp_blk++;
    endtask

    task automatic send_parity(input logic [BW-1:0] w, input int gap);
`ifdef CFG_PARITY_EN
        send_bit(^w, gap);
`else
        if (gap < 0) $display("gap %0d %h", gap, w);
`endif
    endtask

    task automatic send_word(input logic [BW-1:0] w, input int gap);
        expect_word(w);
        send_range(w, BW - 1, 0, gap);
        send_parity(w, gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        exp_blk = 0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
        cfg_valid = 1'b0;
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done: got %b want 1", nm, done);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        n_chk++;
        if ({bits, wr_en, cfg_ready, busy, done, err} !== '0) begin
            n_fail++;
            $display("FAIL %s: bits=%h wr_en=%b rdy=%b busy=%b done=%b err=%b want all 0",
                     nm, bits, wr_en, cfg_ready, busy, done, err);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle");
    endtask

    task automatic test_stream();
        logic [BW-1:0] w[4] = '{18'h2A5C3, 18'h00001, 18'h3FFFF, 18'h15A5A};
        wr_cyc.delete();
        pulse_start();
        for (int k = 0; k < 4; k++) send_word(w[k], 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_last_write: done=%b busy=%b want 0 1", done, busy);
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_done: done=%b busy=%b rdy=%b want 1 0 0",
                     done, busy, cfg_ready);
        end
        n_chk++;
        if (wr_cyc.size() != 4) begin
            n_fail++;
            $display("FAIL stream_writes: got %0d want 4", wr_cyc.size());
        end
        for (int k = 0; k < wr_cyc.size() && k < 4; k++) begin
            n_chk++;
            if (wr_cyc[k] - start_cyc != PER - 1 + PER * k) begin
                n_fail++;
                $display("FAIL stream_latency%0d: got %0d want %0d", k,
                         wr_cyc[k] - start_cyc, PER - 1 + PER * k);
            end
        end
    endtask

    task automatic test_bubbles();
        logic [BW-1:0] w[4] = '{18'h2A5C3, 18'h00001, 18'h3FFFF, 18'h15A5A};
        pulse_start();
        for (int k = 0; k < 4; k++) send_word(w[k], 40);
        wait_done("bubbles");
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_word(18'h1B2C4, 0);
        send_range(18'h0F0F0, BW - 1, BW - 7, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid");
        cfg_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_mid_idle");
        pulse_start();
        send_word(18'h12345, 0);
        send_word(18'h3C3C3, 0);
        send_word(18'h00F00, 30);
        send_word(18'h2AAAA, 0);
        wait_done("reset_mid");
    endtask

    task automatic test_start_ignored();
        pulse_start();
        expect_word(18'h25A96);
        send_range(18'h25A96, BW - 1, BW - 5, 0);
        @(negedge clk);
        start = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored: busy=%b rdy=%b want 1 1", busy, cfg_ready);
        end
        send_range(18'h25A96, BW - 6, 0, 0);
        send_parity(18'h25A96, 0);
        send_word(18'h0000F, 0);
        send_word(18'h3F000, 0);
        send_word(18'h15A5A, 0);
        wait_done("start_ignored");
    endtask

    task automatic test_restart_done();
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_pre: done=%b want 1", done);
        end
        pulse_start();
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: done=%b busy=%b want 0 1", done, busy);
        end
        for (int k = 0; k < 4; k++) send_word(18'h00000, 0);
        wait_done("restart");
    endtask

`ifdef CFG_PARITY_EN
    task automatic test_parity();
        pulse_start();
        send_word(18'h00003, 0);
        send_range(18'h00001, BW - 1, 0, 0);
        send_bit(1'b0, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        n_chk++;
        if (err !== 1'b1 || wr_en !== '0 || bits !== 18'h00003 ||
            cfg_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_err: err=%b wr_en=%b bits=%h rdy=%b busy=%b want 1 0 00003 0 0",
                     err, wr_en, bits, cfg_ready, busy);
        end
        repeat (3) @(negedge clk);
        pulse_start();
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_clear: err=%b busy=%b want 0 1", err, busy);
        end
        for (int k = 0; k < 4; k++) send_word(BW'(k * 18'h0A5A5 + 1), 0);
        wait_done("parity");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_bubbles();
        test_reset_mid();
        test_start_ignored();
        test_restart_done();
`ifdef CFG_PARITY_EN
        test_parity();
`endif
        n_chk++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_final: got %b want 0", err);
        end
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
